// File: rtl/prime_power_reader.sv
// prime_power_reader
//   Reader side of the sieve bitmap. A start pulse captures a completed
//   prime bitmap (bit i set means i is prime). The bitmap is then scanned
//   upward from index 2. For every set index p <= BOUND, the reader finds
//   the largest p^e <= BOUND and emits the record (p, p^e, e) on a
//   valid/ready stream to the Pollard p-1 exponentiation stage.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse; captures prime_map and begins a scan
//              (ignored while busy)
//   prime_map  sieve bitmap, sampled only on an accepted start edge
//   out_valid  a record is available
//   out_ready  consumer accepts the record when out_valid & out_ready
//   out_prime  prime p
//   out_power  largest p^e <= BOUND
//   out_exp    exponent e (>= 1)
//   busy       scan in progress (SCAN/POWER/EMIT)
//   done       scan finished; held until the next start or reset
module prime_power_reader #(
    parameter int unsigned N_BITS = 256,
    parameter int unsigned IDX_W  = 9,
    parameter int unsigned BOUND  = 255,
    parameter int unsigned PW_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] prime_map,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_prime,
    output logic [PW_W-1:0]   out_power,
    output logic [3:0]        out_exp,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MAP_AW = $clog2(N_BITS);
    localparam logic [IDX_W-1:0]  BOUND_I = IDX_W'(BOUND);
    localparam logic [2*PW_W-1:0] BOUND_P = (2*PW_W)'(BOUND);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        POWER,
        EMIT,
        DONE
    } state_t;

    state_t             state;
    logic [N_BITS-1:0]  map;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   p;
    logic [PW_W-1:0]    pw;
    logic [3:0]         e;
    logic [2*PW_W-1:0]  prod;

    // Full double-width product so the overflow test can never be fooled
    // by truncation.
    always_comb begin
        prod = {{PW_W{1'b0}}, pw} * {{(2*PW_W-IDX_W){1'b0}}, p};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            map       <= '0;
            idx       <= '0;
            p         <= '0;
            pw        <= '0;
            e         <= '0;
            out_valid <= 1'b0;
            out_prime <= '0;
            out_power <= '0;
            out_exp   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        map   <= prime_map;
                        idx   <= IDX_W'(2);
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (idx > BOUND_I) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (map[idx[MAP_AW-1:0]]) begin
                        p     <= idx;
                        pw    <= PW_W'(idx);
                        e     <= 4'd1;
                        state <= POWER;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                POWER: begin
                    if (prod <= BOUND_P) begin
                        pw <= prod[PW_W-1:0];
                        e  <= e + 4'd1;
                    end else begin
                        // Record fields are latched once here so they stay
                        // stable for as long as the consumer stalls.
                        out_prime <= p;
                        out_power <= pw;
                        out_exp   <= e;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= idx + IDX_W'(1);
                        state     <= SCAN;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_power_reader.sv
// Self-checking bench for prime_power_reader. Two instances: A with
// BOUND=255 and B with BOUND=15. A record-level model predicts, for each
// start, the ordered list of records and how many clock edges separate
// each record (and the final done) from the preceding start or handshake.
// Every cycle the DUT outputs are compared against that model.
module tb_prime_power_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetA, startA, readyA, validA, busyA, doneA;
    logic [255:0] mapA;
    logic [8:0]   primeA;
    logic [15:0]  powerA;
    logic [3:0]   expA;

    logic         resetB, startB, readyB, validB, busyB, doneB;
    logic [255:0] mapB;
    logic [8:0]   primeB;
    logic [15:0]  powerB;
    logic [3:0]   expB;

    prime_power_reader #(.N_BITS(256), .IDX_W(9), .BOUND(255), .PW_W(16)) dutA (
        .clk(clk), .reset(resetA), .start(startA), .prime_map(mapA),
        .out_valid(validA), .out_ready(readyA), .out_prime(primeA),
        .out_power(powerA), .out_exp(expA), .busy(busyA), .done(doneA)
    );

    prime_power_reader #(.N_BITS(256), .IDX_W(9), .BOUND(15), .PW_W(16)) dutB (
        .clk(clk), .reset(resetB), .start(startB), .prime_map(mapB),
        .out_valid(validB), .out_ready(readyB), .out_prime(primeB),
        .out_power(powerB), .out_exp(expB), .busy(busyB), .done(doneB)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        int p;
        int pw;
        int e;
        int lat;
        bit fin;
    } ev_t;

    ev_t ev   [0:1][0:299];
    int  evN  [0:1] = '{0, 0};
    int  evHead [0:1] = '{0, 0};
    int  waitCnt [0:1] = '{0, 0};
    bit  mBusy [0:1] = '{0, 0};
    bit  mDone [0:1] = '{0, 0};
    bit  mValid [0:1] = '{0, 0};
    ev_t logv [0:1][0:1023];
    int  logN [0:1] = '{0, 0};

    function automatic int bndOf(input int k);
        return (k == 0) ? 255 : 15;
    endfunction

    // Expected record list for a captured map: each entry carries the number
    // of edges from the previous start/handshake until it becomes valid
    // (one per index visited plus e multiply cycles); the final entry is the
    // done event (remaining indices plus the out-of-range exit cycle).
    task automatic build(input int k, input logic [255:0] m);
        int sc;
        sc = 0;
        evN[k] = 0;
        evHead[k] = 0;
        for (int i = 2; i <= bndOf(k); i++) begin
            sc++;
            if (m[i]) begin
                int pw;
                int e;
                pw = i;
                e  = 1;
                while (pw * i <= bndOf(k)) begin
                    pw = pw * i;
                    e++;
                end
                ev[k][evN[k]] = '{p: i, pw: pw, e: e, lat: sc + e, fin: 1'b0};
                evN[k]++;
                sc = 0;
            end
        end
        ev[k][evN[k]] = '{p: 0, pw: 0, e: 0, lat: sc + 1, fin: 1'b1};
        evN[k]++;
    endtask

    task automatic modelStep(input int k, input bit rst, input bit st, input bit rdy,
                             input logic [255:0] m);
        if (rst) begin
            mBusy[k]  = 1'b0;
            mDone[k]  = 1'b0;
            mValid[k] = 1'b0;
        end else if (!mBusy[k] && st) begin
            build(k, m);
            mBusy[k]   = 1'b1;
            mDone[k]   = 1'b0;
            mValid[k]  = 1'b0;
            waitCnt[k] = ev[k][0].lat;
        end else if (mBusy[k]) begin
            if (mValid[k]) begin
                if (rdy) begin
                    if (logN[k] < 1024) begin
                        logv[k][logN[k]] = ev[k][evHead[k]];
                        logN[k]++;
                    end
                    mValid[k] = 1'b0;
                    evHead[k]++;
                    waitCnt[k] = ev[k][evHead[k]].lat;
                end
            end else begin
                waitCnt[k]--;
                if (waitCnt[k] == 0) begin
                    if (ev[k][evHead[k]].fin) begin
                        mBusy[k] = 1'b0;
                        mDone[k] = 1'b1;
                    end else begin
                        mValid[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        modelStep(0, resetA, startA, readyA, mapA);
        modelStep(1, resetB, startB, readyB, mapB);
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmpDut(input int k, input logic v, input logic b, input logic d,
                          input logic [8:0] pr, input logic [15:0] pw, input logic [3:0] ex);
        string pre;
        pre = (k == 0) ? "A" : "B";
        check({pre, ".out_valid"}, v, mValid[k]);
        check({pre, ".busy"}, b, mBusy[k]);
        check({pre, ".done"}, d, mDone[k]);
        if (mValid[k]) begin
            check({pre, ".out_prime"}, pr, ev[k][evHead[k]].p);
            check({pre, ".out_power"}, pw, ev[k][evHead[k]].pw);
            check({pre, ".out_exp"}, ex, ev[k][evHead[k]].e);
        end
    endtask

    always @(negedge clk) begin
        cmpDut(0, validA, busyA, doneA, primeA, powerA, expA);
        cmpDut(1, validB, busyB, doneB, primeB, powerB, expB);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chkRec(input int k, input int i, input int p, input int pw, input int e);
        string nm;
        nm = $sformatf("%s.rec%0d", (k == 0) ? "A" : "B", i);
        check({nm, ".p"}, logv[k][i].p, p);
        check({nm, ".pw"}, logv[k][i].pw, pw);
        check({nm, ".e"}, logv[k][i].e, e);
    endtask

    task automatic waitDoneA(input int limit);
        int n;
        n = 0;
        while (!doneA && n < limit) begin
            tick();
            n++;
        end
        check("A.done_reached", doneA, 1);
    endtask

    task automatic waitValidA(input int limit);
        int n;
        n = 0;
        while (!validA && n < limit) begin
            tick();
            n++;
        end
        check("A.valid_reached", validA, 1);
    endtask

    task automatic pulseStartA;
        startA = 1'b1;
        tick();
        startA = 1'b0;
    endtask

    function automatic logic [255:0] primeMap();
        logic [255:0] m;
        m = '0;
        for (int i = 2; i < 256; i++) begin
            bit pr;
            pr = 1'b1;
            for (int d = 2; d * d <= i; d++)
                if (i % d == 0) pr = 1'b0;
            m[i] = pr;
        end
        return m;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int baseA;
        int baseB;
        int n;

        resetA = 1'b1; resetB = 1'b1;
        startA = 1'b0; startB = 1'b0;
        readyA = 1'b1; readyB = 1'b1;
        mapA   = primeMap();
        mapB   = '1;
        repeat (3) tick();
        check("A.reset_valid", validA, 0);
        check("A.reset_busy", busyA, 0);
        check("A.reset_done", doneA, 0);
        check("A.reset_prime", primeA, 0);
        check("B.reset_valid", validB, 0);
        check("B.reset_done", doneB, 0);
        resetA = 1'b0; resetB = 1'b0;
        tick();

        // T1 (A, real primes) and T4 (B, all-ones map, BOUND=15)
        baseA = logN[0];
        baseB = logN[1];
        startA = 1'b1; startB = 1'b1;
        tick();
        startA = 1'b0; startB = 1'b0;
        // p=2: one scan edge plus seven multiply edges after the start edge
        n = 0;
        while (!validA && n < 50) begin
            tick();
            n++;
        end
        check("A.first_latency", n, 8);
        waitDoneA(3000);
        check("A.T1_count", logN[0] - baseA, 54);
        chkRec(0, baseA + 0, 2, 128, 7);
        chkRec(0, baseA + 1, 3, 243, 5);
        chkRec(0, baseA + 2, 5, 125, 3);
        chkRec(0, baseA + 3, 7, 49, 2);
        chkRec(0, baseA + 6, 17, 17, 1);
        chkRec(0, baseA + 53, 251, 251, 1);
        check("A.T1_busy_end", busyA, 0);
        check("B.T4_done", doneB, 1);
        check("B.T4_count", logN[1] - baseB, 14);
        chkRec(1, baseB + 0, 2, 8, 3);
        chkRec(1, baseB + 1, 3, 9, 2);
        chkRec(1, baseB + 2, 4, 4, 1);
        chkRec(1, baseB + 13, 15, 15, 1);

        // T6 restart from DONE, start during POWER of p=3, and T2 backpressure on (3,243,5)
        baseA = logN[0];
        pulseStartA();
        n = 0;
        while (logN[0] - baseA < 1 && n < 50) begin
            tick();
            n++;
        end
        check("A.T6_first_accept", logN[0] - baseA, 1);
        chkRec(0, baseA, 2, 128, 7);
        tick();
        readyA = 1'b0;
        pulseStartA();
        waitValidA(50);
        check("A.T2_hold_prime", primeA, 3);
        repeat (5) tick();
        check("A.T2_still_valid", validA, 1);
        readyA = 1'b1;
        waitDoneA(3000);
        check("A.T2_count", logN[0] - baseA, 54);
        chkRec(0, baseA + 1, 3, 243, 5);
        chkRec(0, baseA + 2, 5, 125, 3);

        // T3 all-zero map
        baseA = logN[0];
        mapA = '0;
        pulseStartA();
        n = 0;
        while (!doneA && n < 400) begin
            tick();
            n++;
        end
        check("A.T3_done_latency", n, 255);
        check("A.T3_count", logN[0] - baseA, 0);

        // T5 reset while stalled in EMIT
        mapA = primeMap();
        readyA = 1'b0;
        pulseStartA();
        waitValidA(50);
        repeat (2) tick();
        resetA = 1'b1;
        tick();
        resetA = 1'b0;
        check("A.T5_valid", validA, 0);
        check("A.T5_busy", busyA, 0);
        check("A.T5_done", doneA, 0);
        readyA = 1'b1;
        baseA = logN[0];
        pulseStartA();
        waitDoneA(3000);
        check("A.T5_count", logN[0] - baseA, 54);
        chkRec(0, baseA, 2, 128, 7);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
